// File: rtl/park_pay_station_pkg.sv
// Shared definitions for the pay station: default parameters, payment FSM
// state codes and a small saturation helper.
package park_pay_station_pkg;

  localparam int unsigned PMAX_DEFAULT     = 5;
  localparam int unsigned TW_DEFAULT       = 8;
  localparam int unsigned FW_DEFAULT       = 10;
  localparam int unsigned PRESCALE_DEFAULT = 1000;
  localparam int unsigned RATE_DEFAULT     = 2;
  localparam int unsigned COIN_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CALC    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_PAID    = 2'd3
  } pay_state_e;

  // Clamp value to limit.
  function automatic int unsigned sat_max(input int unsigned value,
                                          input int unsigned limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/park_pay_station_timebase.sv
// Time base: prescaler counting 0..PRESCALE-1 and a wrapping time counter.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active low
//   now  - current time unit, wraps mod 2^TW
//   tick - one-cycle pulse in the first cycle of each new time unit
module park_timebase #(
  parameter int unsigned TW       = 8,
  parameter int unsigned PRESCALE = 1000
) (
  input  logic          clk,
  input  logic          rst,
  output logic [TW-1:0] now,
  output logic          tick
);

  localparam int unsigned PW = $clog2(PRESCALE);

  logic [PW-1:0] pcnt;
  logic          wrap;

  assign wrap = (pcnt == PW'(PRESCALE - 1));

  // Prescaler and time counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt <= '0;
      now  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      if (wrap) begin
        pcnt <= '0;
        now  <= now + TW'(1);
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/park_pay_station.sv
// Car-park payment station: issues time-stamped tickets on entry, and on an
// exit request computes the fee, collects coins, pulses pay, returns change
// and frees the place.
// Ports:
//   clk, rst                 - clock, synchronous active-low reset
//   entry_stb                - car passed the entry bar (pulse)
//   ticket_valid, ticket_id  - newly issued ticket (pulse + slot index)
//   full                     - every slot occupied
//   exit_req, exit_id        - pay request for a ticket (pulse + slot index)
//   coin_valid, coin_val     - coin inserted this cycle and its value
//   cancel                   - abort payment and refund credit
//   busy                     - payment transaction in progress
//   fee                      - fee of the current transaction
//   pay                      - payment complete pulse for the car-park
//   change                   - change or refund, valid only in that pulse
//   err                      - ticket refused or bad exit request (pulse)
module park_pay_station
  import park_pay_station_pkg::*;
#(
  parameter  int unsigned PMAX     = PMAX_DEFAULT,
  parameter  int unsigned TW       = TW_DEFAULT,
  parameter  int unsigned FW       = FW_DEFAULT,
  parameter  int unsigned PRESCALE = PRESCALE_DEFAULT,
  parameter  int unsigned RATE     = RATE_DEFAULT,
  localparam int unsigned IDW      = (PMAX > 1) ? $clog2(PMAX) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              entry_stb,
  output logic              ticket_valid,
  output logic [IDW-1:0]    ticket_id,
  output logic              full,
  input  logic              exit_req,
  input  logic [IDW-1:0]    exit_id,
  input  logic              coin_valid,
  input  logic [COIN_W-1:0] coin_val,
  input  logic              cancel,
  output logic              busy,
  output logic [FW-1:0]     fee,
  output logic              pay,
  output logic [FW-1:0]     change,
  output logic              err
);

  localparam int unsigned IDN     = 1 << IDW;
  localparam int unsigned FEE_MAX = (32'd1 << FW) - 32'd1;

  // Time base
  logic [TW-1:0] now;
  logic          tick_unused;

  park_timebase #(
    .TW       (TW),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk  (clk),
    .rst  (rst),
    .now  (now),
    .tick (tick_unused)
  );

  // Slot table
  logic [PMAX-1:0] occ;
  logic [PMAX-1:0] occ_next;
  logic [PMAX-1:0] alloc_mask;
  logic [PMAX-1:0] free_mask;
  logic [IDN-1:0]  occ_pad;
  logic [TW-1:0]   stamp [PMAX];
  logic [IDW-1:0]  free_idx;
  logic            alloc_en;

  // FSM and datapath
  pay_state_e     state, state_next;
  logic [IDW-1:0] cur_id, cur_id_next;
  logic [FW-1:0]  credit, credit_next;
  logic [FW-1:0]  fee_next;
  logic [FW-1:0]  change_next;
  logic           pay_next;
  logic           free_en;
  logic           exit_err;

  logic [TW-1:0]  elapsed;
  logic [TW:0]    units;
  logic [FW-1:0]  fee_calc;
  logic [FW:0]    credit_sum;
  logic [FW-1:0]  credit_add;

  // Padding makes out-of-range ids read as free slots.
  assign occ_pad = IDN'(occ);

  // Lowest free slot; only meaningful while not full.
  always_comb begin
    free_idx = '0;
    for (int i = int'(PMAX) - 1; i >= 0; i--) begin
      if (!occ[i]) free_idx = IDW'(i);
    end
  end

  // Allocation sees pre-edge occupancy, so a slot freed this edge is not reused yet.
  assign alloc_en   = entry_stb && !full;
  assign alloc_mask = alloc_en ? (PMAX'(1) << free_idx) : '0;
  assign free_mask  = free_en ? (PMAX'(1) << cur_id) : '0;
  assign occ_next   = (occ | alloc_mask) & ~free_mask;

  // Fee: subtraction mod 2^TW makes it wrap-safe; every started unit counts.
  assign elapsed  = now - stamp[cur_id];
  assign units    = {1'b0, elapsed} + (TW+1)'(1);
  assign fee_calc = FW'(sat_max(32'(units) * RATE, FEE_MAX));

  // Saturating credit accumulation.
  assign credit_sum = {1'b0, credit} + (FW+1)'(coin_val);
  assign credit_add = credit_sum[FW] ? '1 : credit_sum[FW-1:0];

  // Payment FSM next-state and registered-output values.
  always_comb begin
    state_next  = state;
    cur_id_next = cur_id;
    credit_next = credit;
    fee_next    = fee;
    change_next = '0;
    pay_next    = 1'b0;
    free_en     = 1'b0;
    exit_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (exit_req) begin
          if (occ_pad[exit_id]) begin
            cur_id_next = exit_id;
            state_next  = ST_CALC;
          end else begin
            exit_err = 1'b1;
          end
        end
      end
      ST_CALC: begin
        fee_next    = fee_calc;
        credit_next = '0;
        state_next  = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (coin_valid) credit_next = credit_add;
        // Decision uses the registered credit; a same-cycle coin is still kept.
        if (credit >= fee) begin
          pay_next    = 1'b1;
          change_next = credit_next - fee;
          state_next  = ST_PAID;
        end else if (cancel) begin
          change_next = credit_next;
          state_next  = ST_IDLE;
        end
      end
      ST_PAID: begin
        free_en    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state and payment outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cur_id <= '0;
      credit <= '0;
      fee    <= '0;
      change <= '0;
      pay    <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_next;
      cur_id <= cur_id_next;
      credit <= credit_next;
      fee    <= fee_next;
      change <= change_next;
      pay    <= pay_next;
      busy   <= (state_next != ST_IDLE);
      err    <= (entry_stb && full) || exit_err;
    end
  end

  // Slot table, ticket issue and full flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      occ          <= '0;
      full         <= 1'b0;
      ticket_valid <= 1'b0;
      ticket_id    <= '0;
      for (int i = 0; i < int'(PMAX); i++) stamp[i] <= '0;
    end else begin
      occ          <= occ_next;
      full         <= &occ_next;
      ticket_valid <= alloc_en;
      if (alloc_en) begin
        ticket_id       <= free_idx;
        stamp[free_idx] <= now;
      end
    end
  end

endmodule

// File: tb/tb_park_pay_station.sv
// Scoreboard bench for park_pay_station: the driver predicts every output
// event from a slot/time reference model and queues it; a monitor matches
// DUT output events against the queue.
module tb_park_pay_station;

  localparam int PM = 5;
  localparam int PS = 4;
  localparam int RT = 2;
  localparam int FMAX = 1023;

  localparam int K_TKT = 0;
  localparam int K_ERR = 1;
  localparam int K_PAY = 2;
  localparam int K_REF = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       entry_stb = 1'b0;
  logic       ticket_valid;
  logic [2:0] ticket_id;
  logic       full;
  logic       exit_req = 1'b0;
  logic [2:0] exit_id = 3'd0;
  logic       coin_valid = 1'b0;
  logic [3:0] coin_val = 4'd0;
  logic       cancel = 1'b0;
  logic       busy;
  logic [9:0] fee;
  logic       pay;
  logic [9:0] change;
  logic       err;

  park_pay_station #(
    .PMAX(5), .TW(8), .FW(10), .PRESCALE(4), .RATE(2)
  ) dut (
    .clk(clk), .rst(rst),
    .entry_stb(entry_stb), .ticket_valid(ticket_valid), .ticket_id(ticket_id),
    .full(full), .exit_req(exit_req), .exit_id(exit_id),
    .coin_valid(coin_valid), .coin_val(coin_val), .cancel(cancel),
    .busy(busy), .fee(fee), .pay(pay), .change(change), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rst_seen = 1'b0;

  // cyc = index of the next active edge since reset release.
  always @(posedge clk) begin
    rst_seen <= rst;
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  typedef struct {
    int kind;
    int cyc;
    int val;
    int aux;
  } ev_t;

  ev_t q[$];

  bit occ_m   [PM];
  int stamp_m [PM];
  int ent_pct = 0;

  function automatic int now_at(input int k);
    return (k / PS) % 256;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < PM; i++) if (!occ_m[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int find_ev(input int kind);
    for (int i = 0; i < q.size(); i++) if (q[i].kind == kind) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int val, input int aux);
    ev_t e;
    e.kind = kind; e.cyc = c; e.val = val; e.aux = aux;
    q.push_back(e);
  endtask

  // Monitor: match each DUT output event against the scoreboard.
  bit busy_p = 1'b0;
  bit pay_p  = 1'b0;
  always @(negedge clk) begin
    int  idx;
    bit  refund;
    if (!rst_seen) begin
      busy_p = 1'b0;
      pay_p  = 1'b0;
    end else begin
      refund = busy_p && !busy && !pay_p;
      if (ticket_valid) begin
        idx = find_ev(K_TKT);
        if (idx < 0) begin
          total++; bad++;
          $display("FAIL ticket_unexpected: got id %0d expected none (cyc %0d)", ticket_id, cyc);
        end else begin
          chk("ticket_id", int'(ticket_id), q[idx].val);
          chk("ticket_time", cyc, q[idx].cyc);
          q.delete(idx);
        end
      end
      if (err) begin
        idx = find_ev(K_ERR);
        if (idx < 0) begin
          total++; bad++;
          $display("FAIL err_unexpected: got err=1 expected 0 (cyc %0d)", cyc);
        end else begin
          chk("err_time", cyc, q[idx].cyc);
          q.delete(idx);
        end
      end
      if (pay) begin
        idx = find_ev(K_PAY);
        if (idx < 0) begin
          total++; bad++;
          $display("FAIL pay_unexpected: got pay=1 expected 0 (cyc %0d)", cyc);
        end else begin
          chk("pay_fee", int'(fee), q[idx].val);
          chk("pay_change", int'(change), q[idx].aux);
          chk("pay_time", cyc, q[idx].cyc);
          q.delete(idx);
        end
      end
      if (refund) begin
        idx = find_ev(K_REF);
        if (idx < 0) begin
          total++; bad++;
          $display("FAIL refund_unexpected: got change %0d expected no refund (cyc %0d)", change, cyc);
        end else begin
          chk("refund_change", int'(change), q[idx].val);
          chk("refund_time", cyc, q[idx].cyc);
          q.delete(idx);
        end
      end else if (!pay && change != 10'd0) begin
        chk("change_idle", int'(change), 0);
      end
      // Anything due by now that did not show up is missing.
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc <= cyc) begin
          total++; bad++;
          $display("FAIL event_missing: kind %0d got nothing expected at cyc %0d", q[i].kind, q[i].cyc);
          q.delete(i);
        end
      end
      busy_p = busy;
      pay_p  = pay;
    end
  end

  function automatic bit rnd_ent();
    return (ent_pct > 0) && (int'($urandom_range(0, 99)) < ent_pct);
  endfunction

  // One clock of stimulus; predicts entry/err events and slot occupancy.
  task automatic step(input bit ent, input bit xr, input int xid,
                      input bit cv, input int cval, input bit cc,
                      input bit fr, input int fid, input bit xerr);
    int k;
    bit e;
    k = cyc;
    e = xerr;
    if (ent) begin
      if (model_full()) begin
        e = 1'b1;
      end else begin
        for (int s = 0; s < PM; s++) begin
          if (!occ_m[s]) begin
            occ_m[s]   = 1'b1;
            stamp_m[s] = now_at(k);
            push(K_TKT, k + 1, s, 0);
            break;
          end
        end
      end
    end
    if (e) push(K_ERR, k + 1, 0, 0);
    if (fr) occ_m[fid] = 1'b0;
    entry_stb  = ent;
    exit_req   = xr;
    exit_id    = 3'(xid);
    coin_valid = cv;
    coin_val   = 4'(cval);
    cancel     = cc;
    @(posedge clk);
    #1;
    entry_stb = 1'b0; exit_req = 1'b0; exit_id = 3'd0;
    coin_valid = 1'b0; coin_val = 4'd0; cancel = 1'b0;
    chk("full", int'(full), int'(model_full()));
  endtask

  task automatic idle();
    step(rnd_ent(), 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Full exit transaction: mode 0 pays, mode 1 may cancel once credit > 0.
  task automatic do_exit(input int id, input int mode, input bit ent_free);
    bit badx;
    int units, fm, credit, v;
    bit cv, xr;
    badx = 1'b1;
    if (id >= 0 && id < PM) badx = !occ_m[id];
    step(rnd_ent(), 1'b1, id, 1'b0, 0, 1'b0, 1'b0, 0, badx);
    if (badx) return;
    units = (((now_at(cyc) - stamp_m[id]) % 256) + 256) % 256 + 1;
    fm = units * RT;
    if (fm > FMAX) fm = FMAX;
    idle();
    chk("fee_after_calc", int'(fee), fm);
    credit = 0;
    for (int n = 0; n < 2000; n++) begin
      if (credit >= fm) begin
        push(K_PAY, cyc + 1, fm, credit - fm);
        step(rnd_ent(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             1'b0, 0, 1'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
        step(ent_free ? 1'b1 : rnd_ent(), 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, id, 1'b0);
        return;
      end
      if (mode == 1 && credit > 0 && $urandom_range(0, 2) == 0) begin
        push(K_REF, cyc + 1, credit, 0);
        step(rnd_ent(), 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 0, 1'b0);
        return;
      end
      cv = ($urandom_range(0, 3) != 0);
      v  = int'($urandom_range(1, 15));
      xr = ($urandom_range(0, 4) == 0);
      step(rnd_ent(), xr, int'($urandom_range(0, 7)), cv, v, 1'b0, 1'b0, 0, 1'b0);
      if (cv) credit = (credit + v > FMAX) ? FMAX : credit + v;
    end
    total++; bad++;
    $display("FAIL exit_timeout: got no pay expected pay within budget (cyc %0d)", cyc);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    entry_stb = 1'b0; exit_req = 1'b0; exit_id = 3'd0;
    coin_valid = 1'b0; coin_val = 4'd0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < PM; i++) begin
      occ_m[i]   = 1'b0;
      stamp_m[i] = 0;
    end
    chk("rst_ticket_valid", int'(ticket_valid), 0);
    chk("rst_ticket_id", int'(ticket_id), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fee", int'(fee), 0);
    chk("rst_pay", int'(pay), 0);
    chk("rst_change", int'(change), 0);
    chk("rst_err", int'(err), 0);
  endtask

  initial begin
    int r;
    reset_dut();

    // First ticket stamped at time 3, then fill up and overflow.
    while (cyc < 12) idle();
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);

    // Pay at time 10 while full, with an entry on the freeing edge.
    while (cyc < 40) idle();
    do_exit(0, 0, 1'b1);
    idle();
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);

    // Cancel, then re-exit the same ticket; then invalid requests.
    do_exit(1, 1, 1'b0);
    do_exit(1, 0, 1'b0);
    do_exit(7, 0, 1'b0);
    do_exit(5, 0, 1'b0);
    do_exit(1, 0, 1'b0);

    // Reset in the middle of collecting coins.
    step(1'b0, 1'b1, 2, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 5, 1'b0, 1'b0, 0, 1'b0);
    reset_dut();
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);

    // Random traffic; long runs wrap the time counter several times.
    ent_pct = 25;
    repeat (300) begin
      r = int'($urandom_range(0, 9));
      if (r < 3) begin
        repeat ($urandom_range(1, 40)) idle();
      end else begin
        do_exit(int'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0) ? 1 : 0,
                1'($urandom_range(0, 3) == 0));
      end
    end

    ent_pct = 0;
    repeat (3) idle();
    @(negedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
